// File: rtl/data_sram_like_ctrl.sv
// data_sram_like_ctrl: M-stage load/store to SRAM-like req/addr_ok/data_ok bridge with pipeline stall
module data_sram_like_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_en,
    input  logic [3:0]       mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [1:0]       mem_size,
    input  logic             pipe_stall,
    input  logic             flush_except,
    output logic [31:0]      mem_rdata,
    output logic             stallreq_from_mem,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state;
    logic [31:0] rdata_buf;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_wr;
    logic        abort;
    logic        issue;

    // Request fields pass through in IDLE and come from the captured copy while the request waits
    always_comb begin
        issue             = state == IDLE && mem_en && !flush_except;
        data_req          = issue || state == ADDR;
        data_wr           = state == IDLE ? |mem_wen : req_wr;
        data_size         = state == IDLE ? mem_size : req_size;
        data_addr         = state == IDLE ? mem_addr : req_addr;
        data_wdata        = state == IDLE ? mem_wdata : req_wdata;
        stallreq_from_mem = issue || state == ADDR || (state == DATA && !data_data_ok);
        mem_rdata         = (state == DATA && data_data_ok) ? data_rdata : rdata_buf;
    end

    // Handshake FSM, request capture, load-data buffer and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            rdata_buf    <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_size     <= '0;
            req_wr       <= 1'b0;
            abort        <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stallreq_from_mem && !(&stall_cycles))
                stall_cycles <= stall_cycles + CNT_W'(1);
            case (state)
                IDLE: if (issue) begin
                    req_wr    <= |mem_wen;
                    req_size  <= mem_size;
                    req_addr  <= mem_addr;
                    req_wdata <= mem_wdata;
                    state     <= data_addr_ok ? DATA : ADDR;
                end
                ADDR: begin
                    if (flush_except) abort <= 1'b1;
                    if (data_addr_ok) state <= DATA;
                end
                DATA: if (data_data_ok) begin
                    rdata_buf <= data_rdata;
                    abort     <= 1'b0;
                    state     <= (!abort && pipe_stall) ? HOLD : IDLE;
                end else if (flush_except) begin
                    abort <= 1'b1;
                end
                HOLD: if (!pipe_stall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sram_like_ctrl.sv
// tb_data_sram_like_ctrl: transaction-level reference checks of the data-side SRAM-like bridge
module tb_data_sram_like_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        pipe_stall;
    logic        flush_except;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    // Reference model state: last data returned and expected stall count
    logic [31:0] model_buf = '0;
    logic [31:0] model_cnt = '0;

    data_sram_like_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .pipe_stall(pipe_stall),
        .flush_except(flush_except), .mem_rdata(mem_rdata),
        .stallreq_from_mem(stallreq_from_mem), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0; mem_size = '0;
        pipe_stall = 1'b0; flush_except = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    endtask

    // One access: addr_ok a cycles after issue, data_ok d cycles after that,
    // pipe_stall high for hold cycles starting at data_ok, flush at cycle f (-1 = none)
    task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input int a, input int d, input int hold,
                           input int f, input logic [31:0] rd, input string name);
        int t = a + d;
        bit ab = f >= 0;
        int last = ab ? t : t + hold;
        logic wr = |wen;
        logic [31:0] ret = wr ? model_buf : rd;
        for (int k = 0; k <= last; k++) begin
            mem_en       = 1'b1;
            flush_except = k == f;
            pipe_stall   = k >= t && k < t + hold;
            mem_wen      = k == 0 ? wen : 4'($urandom);
            mem_addr     = k == 0 ? addr : $urandom;
            mem_wdata    = k == 0 ? wdata : $urandom;
            mem_size     = k == 0 ? size : 2'($urandom_range(0, 2));
            data_addr_ok = k == a;
            data_data_ok = k == t;
            data_rdata   = k == t ? ret : $urandom;
            @(negedge clk);
            checks++;
            if (data_req !== (k <= a)) begin
                failures++;
                $display("FAIL %s req k=%0d got=%b exp=%b", name, k, data_req, k <= a);
            end
            checks++;
            if (stallreq_from_mem !== (k < t)) begin
                failures++;
                $display("FAIL %s stall k=%0d got=%b exp=%b", name, k, stallreq_from_mem, k < t);
            end
            checks++;
            if (mem_rdata !== (k < t ? model_buf : ret)) begin
                failures++;
                $display("FAIL %s rdata k=%0d got=%h exp=%h", name, k, mem_rdata, k < t ? model_buf : ret);
            end
            if (k <= a) begin
                checks++;
                if ({data_wr, data_size, data_addr, data_wdata} !== {wr, size, addr, wdata}) begin
                    failures++;
                    $display("FAIL %s fields k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", name, k,
                             data_wr, data_size, data_addr, data_wdata, wr, size, addr, wdata);
                end
            end
            if (k < t) model_cnt++;
            @(posedge clk); #1;
        end
        model_buf = ret;
        idle_inputs();
        checks++;
        if (stall_cycles !== model_cnt) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_cycles, model_cnt);
        end
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        checks++;
        if ({data_req, stallreq_from_mem, mem_rdata, stall_cycles} !== {2'b00, model_buf, model_cnt}) begin
            failures++;
            $display("FAIL %s req=%b stall=%b rdata=%h cnt=%0d exp req=0 stall=0 rdata=%h cnt=%0d",
                     name, data_req, stallreq_from_mem, mem_rdata, stall_cycles, model_buf, model_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_buf = '0; model_cnt = '0;
        check_quiet("reset");
    endtask

    task automatic test_load_basic();
        run_txn(4'b0000, 32'h8000_0010, 32'h0, 2'd2, 0, 2, 0, -1, 32'hDEAD_BEEF, "load_basic");
        checks++;
        if (stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL load_basic_cnt got=%0d exp=2", stall_cycles);
        end
    endtask

    task automatic test_store_wait();
        run_txn(4'b0011, 32'h8000_1004, 32'h1234_5678, 2'd1, 3, 1, 0, -1, 32'h0, "store_wait");
    endtask

    task automatic test_hold();
        run_txn(4'b0000, 32'h8000_0020, 32'h0, 2'd2, 1, 1, 2, -1, 32'hA5A5_A5A5, "hold");
        check_quiet("hold_after");
    endtask

    task automatic test_flush();
        run_txn(4'b0000, 32'h8000_0030, 32'h0, 2'd2, 0, 3, 1, 1, 32'h0BAD_F00D, "flush_data");
        run_txn(4'b0000, 32'h8000_0034, 32'h0, 2'd2, 2, 2, 1, 1, 32'h1357_9BDF, "flush_addr");
        run_txn(4'b0000, 32'h8000_0038, 32'h0, 2'd2, 0, 1, 0, -1, 32'h2468_ACE0, "after_flush");
    endtask

    task automatic test_flush_idle();
        mem_en = 1'b1; flush_except = 1'b1;
        check_quiet("flush_idle");
    endtask

    task automatic test_back_to_back();
        run_txn(4'b0000, 32'h8000_0100, 32'h0, 2'd2, 0, 1, 0, -1, 32'h1111_1111, "b2b_first");
        run_txn(4'b0000, 32'h8000_0104, 32'h0, 2'd2, 0, 1, 0, -1, 32'h2222_2222, "b2b_second");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] wen = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            int a = $urandom_range(0, 3);
            int d = $urandom_range(1, 3);
            int hold = $urandom_range(0, 2);
            int f = -1;
            if ($urandom_range(0, 3) == 0) begin
                if (a + d < 2) d = 2;
                f = $urandom_range(1, a + d - 1);
                hold = $urandom_range(0, 1);
            end
            run_txn(wen, $urandom, $urandom, 2'($urandom_range(0, 2)), a, d, hold, f, $urandom, "random");
            repeat ($urandom_range(0, 1)) check_quiet("random_gap");
        end
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b1; mem_addr = 32'h8000_0200; mem_size = 2'd2; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_buf = '0; model_cnt = '0;
        check_quiet("reset_mid");
        run_txn(4'b0000, 32'h8000_0204, 32'h0, 2'd2, 1, 1, 0, -1, 32'hCAFE_0001, "post_reset");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_basic();
        test_store_wait();
        test_hold();
        test_flush();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
